bg_theme_ctrl: RTL and testbench

BG_THEME_CTRL -- requirements
Module: bg_theme_ctrl

---
 rtl/bg_theme_ctrl.sv | 102 ++++++++++
 tb/tb_bg_theme_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bg_theme_ctrl.sv
// Background fill-colour controller: arbitrates colour requests and applies them on frame boundaries.
// Define BG_THEME_FADE_EN to fade one nibble step per frame instead of a one-step apply.
module bg_theme_ctrl #(
   parameter logic [11:0] DEFAULT_RGB = 12'h888
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vblnk,
   input  logic [1:0]  req,
   input  logic [11:0] color0,
   input  logic [11:0] color1,
   output logic [1:0]  ack,
   output logic        busy,
   output logic [11:0] fill_rgb,
   output logic [7:0]  frame_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_APPLY = 2'd2;

   logic [1:0]  r_state;
   logic        r_vblnk_d;
   logic [11:0] r_target;
   logic [11:0] r_fill;
   logic [1:0]  r_ack;
   logic [7:0]  r_cnt;
   logic        r_ptr;

   logic        w_tick;
   logic        w_gnt1;
   logic [11:0] w_color;

   assign w_tick = vblnk & ~r_vblnk_d;

   // Contention goes to the pointer; a lone request always wins.
   always_comb begin
      w_gnt1 = 1'b0;
      if (req == 2'b11) w_gnt1 = r_ptr;
      else              w_gnt1 = req[1];
   end

   assign w_color = w_gnt1 ? color1 : color0;

`ifdef BG_THEME_FADE_EN
   function automatic logic [3:0] f_step(input logic [3:0] c, input logic [3:0] t);
      if (c < t)      f_step = c + 4'd1;
      else if (c > t) f_step = c - 4'd1;
      else            f_step = c;
   endfunction
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_vblnk_d <= 1'b1;
         r_target  <= DEFAULT_RGB;
         r_fill    <= DEFAULT_RGB;
         r_ack     <= 2'b00;
         r_cnt     <= 8'd0;
         r_ptr     <= 1'b0;
      end else begin
         r_vblnk_d <= vblnk;
         r_ack     <= 2'b00;
         if (w_tick) r_cnt <= r_cnt + 8'd1;
         case (r_state)
            S_IDLE: begin
               if (req != 2'b00) begin
                  r_ack    <= w_gnt1 ? 2'b10 : 2'b01;
                  r_target <= w_color;
                  r_ptr    <= ~w_gnt1;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_tick) r_state <= S_APPLY;
            end
            S_APPLY: begin
`ifdef BG_THEME_FADE_EN
               if (r_fill == r_target) begin
                  r_state <= S_IDLE;
               end else if (w_tick) begin
                  r_fill <= {f_step(r_fill[11:8], r_target[11:8]),
                             f_step(r_fill[7:4],  r_target[7:4]),
                             f_step(r_fill[3:0],  r_target[3:0])};
               end
`else
               r_fill  <= r_target;
               r_state <= S_IDLE;
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ack       = r_ack;
   assign busy      = (r_state != S_IDLE);
   assign fill_rgb  = r_fill;
   assign frame_cnt = r_cnt;

endmodule

// File: tb/tb_bg_theme_ctrl.sv
// Directed self-checking bench for bg_theme_ctrl.
// Fade checks are compiled only with BG_THEME_FADE_EN.
module tb_bg_theme_ctrl;

   logic        clk;
   logic        rst_n;
   logic        vblnk;
   logic [1:0]  req;
   logic [11:0] color0;
   logic [11:0] color1;
   logic [1:0]  ack;
   logic        busy;
   logic [11:0] fill_rgb;
   logic [7:0]  frame_cnt;

   int total = 0;
   int bad   = 0;

   bg_theme_ctrl #(.DEFAULT_RGB(12'h888)) dut (
      .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .req(req),
      .color0(color0), .color1(color1), .ack(ack), .busy(busy),
      .fill_rgb(fill_rgb), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full vblnk low-high cycle; the tick is seen on the second edge.
   task automatic frame();
      vblnk = 1'b0; step();
      vblnk = 1'b1; step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0; vblnk = 1'b1; req = 2'b00;
      color0 = 12'h000; color1 = 12'h000;
      step(); step();
      chk("rst_fill", fill_rgb, 12'h888);
      chk("rst_cnt", {4'h0, frame_cnt}, 12'h000);
      chk("rst_busy", {11'h0, busy}, 12'h000);
      chk("rst_ack", {10'h0, ack}, 12'h000);

      rst_n = 1'b1;
      step(); step(); step();
      chk("no_tick_after_rel", {4'h0, frame_cnt}, 12'h000);
      frame();
      chk("first_tick", {4'h0, frame_cnt}, 12'h001);

      // single request from requester 0
      vblnk = 1'b0; req = 2'b01; color0 = 12'h0F0;
      step();
      chk("g0_ack", {10'h0, ack}, 12'h001);
      chk("g0_busy", {11'h0, busy}, 12'h001);
      req = 2'b00;
      step();
      chk("g0_ack_pulse", {10'h0, ack}, 12'h000);
      step();
      chk("g0_hold", fill_rgb, 12'h888);
      vblnk = 1'b1; step();
      chk("g0_lat1", fill_rgb, 12'h888);
      chk("g0_lat1_busy", {11'h0, busy}, 12'h001);
      step();
      chk("g0_fill", fill_rgb, 12'h0F0);
      chk("g0_idle", {11'h0, busy}, 12'h000);

      // reset while a target is pending
      vblnk = 1'b0; req = 2'b01; color0 = 12'h123;
      step();
      req = 2'b00;
      do_reset();
      chk("midrst_fill", fill_rgb, 12'h888);
      frame(); step();
      chk("midrst_noapply", fill_rgb, 12'h888);
      chk("midrst_idle", {11'h0, busy}, 12'h000);

      // both requesting: round robin after reset starts at 0
      vblnk = 1'b0; req = 2'b11; color0 = 12'h0F0; color1 = 12'hF00;
      step();
      chk("rr1_ack", {10'h0, ack}, 12'h001);
      step();
      vblnk = 1'b1; step(); step();
      chk("rr1_fill", fill_rgb, 12'h0F0);
      chk("rr1_idle", {11'h0, busy}, 12'h000);
      step();
      chk("rr2_ack", {10'h0, ack}, 12'h002);
      req = 2'b00;
      frame(); step();
      chk("rr2_fill", fill_rgb, 12'hF00);

      // request arriving during WAIT_FRAME is deferred
      vblnk = 1'b0; req = 2'b01; color0 = 12'h0AA;
      step();
      chk("w_ack0", {10'h0, ack}, 12'h001);
      req = 2'b10; color1 = 12'h055;
      step();
      chk("w_ignored", {10'h0, ack}, 12'h000);
      frame();
      chk("w_apply_noack", {10'h0, ack}, 12'h000);
      step();
      chk("w_fill0", fill_rgb, 12'h0AA);
      chk("w_idle_noack", {10'h0, ack}, 12'h000);
      step();
      chk("w_ack1", {10'h0, ack}, 12'h002);
      req = 2'b00;
      frame(); step();
      chk("w_fill1", fill_rgb, 12'h055);

      // grant coinciding with a tick waits for the next frame
      vblnk = 1'b0; step();
      req = 2'b01; color0 = 12'h777; vblnk = 1'b1;
      step();
      chk("co_ack", {10'h0, ack}, 12'h001);
      req = 2'b00;
      step(); step();
      chk("co_noapply", fill_rgb, 12'h055);
      chk("co_busy", {11'h0, busy}, 12'h001);
      frame(); step();
      chk("co_fill", fill_rgb, 12'h777);

      // frame counter wrap
      vblnk = 1'b1;
      do_reset();
      for (int i = 0; i < 255; i++) frame();
      chk("cnt_255", {4'h0, frame_cnt}, 12'h0FF);
      frame();
      chk("cnt_wrap", {4'h0, frame_cnt}, 12'h000);

`ifdef BG_THEME_FADE_EN
      do_reset();
      vblnk = 1'b0; req = 2'b01; color0 = 12'h8A5;
      step();
      req = 2'b00;
      frame();
      chk("fd_enter", fill_rgb, 12'h888);
      frame();
      chk("fd_s1", fill_rgb, 12'h897);
      frame();
      chk("fd_s2", fill_rgb, 12'h8A6);
      frame();
      chk("fd_s3", fill_rgb, 12'h8A5);
      chk("fd_s3_busy", {11'h0, busy}, 12'h001);
      step();
      chk("fd_idle", {11'h0, busy}, 12'h000);
      vblnk = 1'b0; req = 2'b01; color0 = 12'hFFF;
      step();
      req = 2'b00;
      frame(); frame();
      chk("fd2_s1", fill_rgb, 12'h9B6);
      do_reset();
      chk("fd2_rst", fill_rgb, 12'h888);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
